// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Round-robin arbiter plus fill/store sequencer that sits between NUM_PORTS
//   cache ports and one pipelined multicycle memory. Only one request is in
//   flight at a time. A read miss becomes a block fill of WORDS_PER_BLOCK
//   words. A write becomes a single-word write-through store.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   req_miss_i/_write_i  per-port requests, held by the cache until port_done_o
//   req_addr_i/wdata_i   per-port address / store data, port i at [i*W +: W]
//   port_busy_o          one-hot, port being serviced (after grant .. DONE)
//   port_done_o          one-hot single-cycle completion pulse
//   fill_data_we_o       one-hot data-array write strobe, aligned with mem_data_valid_i
//   fill_tag_we_o        one-hot tag-array write strobe, with the last fill word
//   fill_addr_o/data_o   word address / data being written into the data array
//   mem_enable_o/wr_o    memory request strobe and direction (1 = write)
//   mem_addr_o/wdata_o   memory byte address / store data
//   mem_rdata_i/valid_i  memory read return
module cache_fill_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_PORTS-1:0]        req_miss_i,
  input  logic [NUM_PORTS-1:0]        req_write_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata_i,
  output logic [NUM_PORTS-1:0]        port_busy_o,
  output logic [NUM_PORTS-1:0]        port_done_o,
  output logic [NUM_PORTS-1:0]        fill_data_we_o,
  output logic [NUM_PORTS-1:0]        fill_tag_we_o,
  output logic [ADDR_W-1:0]           fill_addr_o,
  output logic [DATA_W-1:0]           fill_data_o,
  output logic                        mem_enable_o,
  output logic                        mem_wr_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  input  logic                        mem_data_valid_i
);

  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORDS_PER_BLOCK * 2 - 1);
  localparam logic [CNT_W-1:0]  NWORDS   = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LASTW    = CNT_W'(WORDS_PER_BLOCK - 1);

  // The sequencer never counts memory latency itself; a fill ends on the last
  // returned beat. The latency parameter is only sanity-checked here.
  if (NUM_PORTS < 1) begin : g_bad_ports
    $error("NUM_PORTS must be >= 1");
  end
  if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_wpb
    $error("WORDS_PER_BLOCK must be a power of 2, >= 2");
  end
  if (MEM_LATENCY < 1) begin : g_bad_lat
    $error("MEM_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e                 state_q;
  logic [PW-1:0]          rr_q;
  logic [ADDR_W-1:0]      base_q;
  logic [CNT_W-1:0]       iss_q, rcv_q;
  logic                   mem_enable_q, mem_wr_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic [NUM_PORTS-1:0]   port_busy_q, port_done_q;

  // ---------------- round-robin pick ----------------
  logic [NUM_PORTS-1:0] pending;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [ADDR_W-1:0]    gnt_addr;
  logic [DATA_W-1:0]    gnt_wdata;

  assign pending = req_miss_i | req_write_i;

  // Scan downwards so the candidate closest to rr_q wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = (int'(rr_q) + i) % NUM_PORTS;
      if (pending[PW'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(j);
      end
    end
    gnt_addr  = req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
    gnt_wdata = req_wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      base_q       <= '0;
      iss_q        <= '0;
      rcv_q        <= '0;
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      port_busy_q  <= '0;
      port_done_q  <= '0;
    end else begin
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      port_done_q  <= '0;
      case (state_q)
        IDLE: if (gnt_vld) begin
          rr_q        <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : PW'(gnt_idx + 1'b1);
          port_busy_q <= NUM_PORTS'(1) << gnt_idx;
          mem_enable_q <= 1'b1;
          // A pending miss always takes precedence over a write on the same port.
          if (req_miss_i[gnt_idx]) begin
            state_q    <= FILL;
            base_q     <= gnt_addr & ~OFF_MASK;
            mem_addr_q <= gnt_addr & ~OFF_MASK;
            iss_q      <= CNT_W'(1);
            rcv_q      <= '0;
          end else begin
            state_q     <= WRITE;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= gnt_addr;
            mem_wdata_q <= gnt_wdata;
          end
        end
        FILL: begin
          // Issue and receive run independently; beats overlap later reads.
          if (iss_q < NWORDS) begin
            mem_enable_q <= 1'b1;
            mem_addr_q   <= base_q | ADDR_W'({iss_q[CNT_W-2:0], 1'b0});
            iss_q        <= iss_q + 1'b1;
          end
          if (mem_data_valid_i) begin
            rcv_q <= rcv_q + 1'b1;
            if (rcv_q == LASTW) begin
              state_q     <= DONE;
              port_done_q <= port_busy_q;
            end
          end
        end
        WRITE: begin
          state_q     <= DONE;
          port_done_q <= port_busy_q;
        end
        DONE: begin
          state_q     <= IDLE;
          port_busy_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array writes follow the memory return in the same cycle.
  logic fill_vld, fill_last;
  assign fill_vld  = (state_q == FILL) && mem_data_valid_i && (rcv_q < NWORDS);
  assign fill_last = fill_vld && (rcv_q == LASTW);

  assign fill_data_we_o = fill_vld  ? port_busy_q : '0;
  assign fill_tag_we_o  = fill_last ? port_busy_q : '0;
  assign fill_addr_o    = fill_vld  ? (base_q | ADDR_W'({rcv_q[CNT_W-2:0], 1'b0})) : '0;
  assign fill_data_o    = fill_vld  ? mem_rdata_i : '0;

  assign mem_enable_o = mem_enable_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign port_busy_o  = port_busy_q;
  assign port_done_o  = port_done_q;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;
  localparam int NP = 2, AW = 16, DW = 16, WPB = 8, LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0]    req_miss = '0, req_write = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_wdata = '0;
  logic [NP-1:0]    port_busy, port_done, fill_data_we, fill_tag_we;
  logic [AW-1:0]    fill_addr, mem_addr;
  logic [DW-1:0]    fill_data, mem_wdata;
  logic             mem_enable, mem_wr;
  logic [DW-1:0]    mem_rdata = '0;
  logic             mem_data_valid = 1'b0;

  cache_fill_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
                       .WORDS_PER_BLOCK(WPB), .MEM_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_miss_i(req_miss), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .port_busy_o(port_busy), .port_done_o(port_done),
    .fill_data_we_o(fill_data_we), .fill_tag_we_o(fill_tag_we),
    .fill_addr_o(fill_addr), .fill_data_o(fill_data),
    .mem_enable_o(mem_enable), .mem_wr_o(mem_wr),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_data_valid_i(mem_data_valid));

  always #5 clk = ~clk;

  int cyc = 0, nchk = 0, nerr = 0;
  int rd_seen = 0, fills_seen = 0, dones_seen = 0;
  int last_rd = 0, last_ev = 0, last_done = 0;

  function automatic logic [DW-1:0] mdata(logic [AW-1:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Pipelined memory: a read sampled in cycle c returns in cycle c+LAT.
  typedef struct { logic [AW-1:0] a; int due; } mreq_t;
  mreq_t mq[$];
  always begin
    @(negedge clk);
    if (mem_enable && !mem_wr) mq.push_back('{mem_addr, cyc + LAT});
    @(posedge clk);
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_rdata      = mdata(mq[0].a);
      void'(mq.pop_front());
    end else begin
      mem_data_valid = 1'b0;
      mem_rdata      = '0;
    end
  end

  // Scoreboard queues.
  typedef struct { int p; logic [AW-1:0] a; int k; int gap; } rd_t;
  typedef struct { int p; logic [AW-1:0] a; logic [DW-1:0] d; bit tag; } fill_t;
  typedef struct { int p; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int p; } done_t;
  rd_t exp_rd[$]; fill_t exp_fill[$]; wr_t exp_wr[$]; done_t exp_done[$];

  function automatic logic [NP-1:0] oh(int p);
    return NP'(1) << p;
  endfunction

  function automatic logic [127:0] all_outs();
    return 128'({port_busy, port_done, fill_data_we, fill_tag_we, fill_addr, fill_data,
                 mem_enable, mem_wr, mem_addr, mem_wdata});
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_miss(int p, logic [AW-1:0] base, int gap);
    logic [AW-1:0] a;
    for (int k = 0; k < WPB; k++) begin
      a = base + AW'(2 * k);
      exp_rd.push_back('{p, a, k, (k == 0) ? gap : 0});
      exp_fill.push_back('{p, a, mdata(a), k == WPB - 1});
    end
    exp_done.push_back('{p});
  endtask

  task automatic push_write(int p, logic [AW-1:0] a, logic [DW-1:0] d);
    exp_wr.push_back('{p, a, d});
    exp_done.push_back('{p});
  endtask

  // One cycle of monitoring, sampled on the falling edge.
  task automatic tick();
    rd_t r; fill_t f; wr_t w; done_t d;
    @(negedge clk);
    if (mem_enable && !mem_wr) begin
      rd_seen++;
      if (exp_rd.size() == 0) chk("unexp_read", 128'(mem_enable), 128'(0));
      else begin
        r = exp_rd.pop_front();
        chk("rd_addr", 128'(mem_addr), 128'(r.a));
        chk("rd_busy", 128'(port_busy), 128'(oh(r.p)));
        if (r.k != 0) chk("rd_consec", 128'(cyc), 128'(last_rd + 1));
        else if (r.gap != 0) chk("grant_gap", 128'(cyc - last_done), 128'(r.gap));
        last_rd = cyc;
      end
    end else if (mem_enable && mem_wr) begin
      if (exp_wr.size() == 0) chk("unexp_write", 128'(mem_enable), 128'(0));
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 128'(mem_addr), 128'(w.a));
        chk("wr_data", 128'(mem_wdata), 128'(w.d));
        chk("wr_busy", 128'(port_busy), 128'(oh(w.p)));
        last_ev = cyc;
      end
    end else chk("mem_idle", 128'({mem_wr, mem_addr, mem_wdata}), 128'(0));

    if (fill_data_we != '0) begin
      fills_seen++;
      if (exp_fill.size() == 0) chk("unexp_fill", 128'(fill_data_we), 128'(0));
      else begin
        f = exp_fill.pop_front();
        chk("fill_we", 128'(fill_data_we), 128'(oh(f.p)));
        chk("fill_tag", 128'(fill_tag_we), f.tag ? 128'(oh(f.p)) : 128'(0));
        chk("fill_addr", 128'(fill_addr), 128'(f.a));
        chk("fill_data", 128'(fill_data), 128'(f.d));
        last_ev = cyc;
      end
    end else chk("fill_idle", 128'({fill_tag_we, fill_addr, fill_data}), 128'(0));

    if (port_done != '0) begin
      dones_seen++;
      if (exp_done.size() == 0) chk("unexp_done", 128'(port_done), 128'(0));
      else begin
        d = exp_done.pop_front();
        chk("done_port", 128'(port_done), 128'(oh(d.p)));
        chk("done_busy", 128'(port_busy), 128'(port_done));
        chk("done_lat", 128'(cyc), 128'(last_ev + 1));
      end
      last_done = cyc;
      // Cache side: the miss is retired first, then the write.
      for (int p = 0; p < NP; p++)
        if (port_done[p]) begin
          if (req_miss[p]) req_miss[p] = 1'b0;
          else req_write[p] = 1'b0;
        end
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (n < budget &&
           (exp_rd.size() + exp_fill.size() + exp_wr.size() + exp_done.size()) != 0) begin
      tick();
      n++;
    end
    chk("drain_timeout", 128'(exp_rd.size() + exp_fill.size() + exp_wr.size() + exp_done.size()),
        128'(0));
    tick();
    chk("idle_busy", 128'(port_busy), 128'(0));
  endtask

  task automatic do_reset();
    req_miss = '0; req_write = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_outs", all_outs(), 128'(0));
    rst_n = 1'b1;
  endtask

  typedef struct {
    int p; bit miss; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int rd0, f0, d0;
    vecs[0] = '{0, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1230};
    vecs[1] = '{1, 1'b0, 1'b1, 16'h00A2, 16'hBEEF, 16'h00A2};
    vecs[2] = '{1, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFF0};
    vecs[3] = '{0, 1'b0, 1'b1, 16'h0001, 16'h1357, 16'h0001};
    vecs[4] = '{0, 1'b1, 1'b0, 16'h000F, 16'h0000, 16'h0000};

    // Reset held, no requests; outputs stay quiet after release.
    repeat (5) tick();
    chk("reset_hold_outs", all_outs(), 128'(0));
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_outs", all_outs(), 128'(0));

    // Single-port operations.
    for (int i = 0; i < 5; i++) begin
      req_addr[vecs[i].p*AW +: AW]  = vecs[i].addr;
      req_wdata[vecs[i].p*DW +: DW] = vecs[i].wdata;
      if (vecs[i].miss) push_miss(vecs[i].p, vecs[i].exp_addr, 0);
      if (vecs[i].wr)   push_write(vecs[i].p, vecs[i].exp_addr, vecs[i].wdata);
      req_miss[vecs[i].p]  = vecs[i].miss;
      req_write[vecs[i].p] = vecs[i].wr;
      drain(80);
    end

    // Both ports miss together from reset: 0 then 1, back to back.
    do_reset();
    req_addr = {16'h0210, 16'h0100};
    push_miss(0, 16'h0100, 0);
    push_miss(1, 16'h0210, 2);
    req_miss = 2'b11;
    drain(100);

    // Port 0 alone moves the pointer to 1; then both pending -> 1 then 0.
    req_addr[0 +: AW] = 16'h0300; req_wdata[0 +: DW] = 16'h1111;
    push_write(0, 16'h0300, 16'h1111);
    req_write[0] = 1'b1;
    drain(40);
    req_addr = {16'h0520, 16'h0400};
    push_miss(1, 16'h0520, 0);
    push_miss(0, 16'h0400, 2);
    req_miss = 2'b11;
    drain(100);

    // Miss and write on the same port: fill first, then the store.
    req_addr[AW +: AW] = 16'h0040; req_wdata[DW +: DW] = 16'h5A5A;
    push_miss(1, 16'h0040, 0);
    push_write(1, 16'h0040, 16'h5A5A);
    req_miss[1] = 1'b1; req_write[1] = 1'b1;
    d0 = dones_seen;
    drain(100);
    chk("miss_write_dones", 128'(dones_seen - d0), 128'(2));

    // Reset during the third read of a fill: immediate quiet, no late effects.
    rd0 = rd_seen;
    req_addr[0 +: AW] = 16'h3456;
    push_miss(0, 16'h3450, 0);
    req_miss[0] = 1'b1;
    for (int i = 0; i < 20 && rd_seen < rd0 + 3; i++) tick();
    chk("abort_reads", 128'(rd_seen - rd0), 128'(3));
    #2 rst_n = 1'b0;
    #1 chk("abort_async", all_outs(), 128'(0));
    req_miss = '0;
    exp_rd.delete(); exp_fill.delete(); exp_wr.delete(); exp_done.delete();
    f0 = fills_seen; d0 = dones_seen;
    tick(); tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("abort_no_fill", 128'(fills_seen - f0), 128'(0));
    chk("abort_no_done", 128'(dones_seen - d0), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
